// File: rtl/alsu_wide.sv
// Parametrised two-stage ALSU with a valid tag, hold-on-bubble behaviour and a saturating invalid-op counter.
// Latency: inputs sampled at edge N update out/out_valid/leds/err_cnt at edge N+1.
// Backpressure: none; accepts one operation per cycle and idles on in_valid=0.
module alsu_wide #(
   parameter int    WIDTH          = 3,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    LED_WIDTH      = 16,
   parameter int    ERR_W          = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic signed [WIDTH-1:0]   A,
   input  logic signed [WIDTH-1:0]   B,
   input  logic                      cin,
   input  logic                      serial_in,
   input  logic                      red_op_A,
   input  logic                      red_op_B,
   input  logic                      bypass_A,
   input  logic                      bypass_B,
   input  logic                      direction,
   input  logic [2:0]                opcode,
   output logic signed [2*WIDTH-1:0] out,
   output logic                      out_valid,
   output logic [LED_WIDTH-1:0]      leds,
   output logic [ERR_W-1:0]          err_cnt
);

   localparam int OW      = 2*WIDTH;
   localparam bit PRI_A   = (INPUT_PRIORITY == "A");
   localparam bit USE_CIN = (FULL_ADDER == "ON");

   logic signed [WIDTH-1:0] a_r, b_r;
   logic                    vld_r, cin_r, ser_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r;
   logic [2:0]              op_r;

   logic signed [OW-1:0]    a_ext, b_ext, nxt_out;
   logic                    invalid, pick_a_red, pick_a_byp;

   // Stage 1: unconditional capture of every input, including the valid tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         vld_r   <= 1'b0;
         cin_r   <= 1'b0;
         ser_r   <= 1'b0;
         red_a_r <= 1'b0;
         red_b_r <= 1'b0;
         byp_a_r <= 1'b0;
         byp_b_r <= 1'b0;
         dir_r   <= 1'b0;
         op_r    <= '0;
      end else begin
         a_r     <= A;
         b_r     <= B;
         vld_r   <= in_valid;
         cin_r   <= cin;
         ser_r   <= serial_in;
         red_a_r <= red_op_A;
         red_b_r <= red_op_B;
         byp_a_r <= bypass_A;
         byp_b_r <= bypass_B;
         dir_r   <= direction;
         op_r    <= opcode;
      end
   end

   // Stage-2 datapath: decode the registered operation into the next result value.
   always_comb begin
      a_ext      = {{WIDTH{a_r[WIDTH-1]}}, a_r};
      b_ext      = {{WIDTH{b_r[WIDTH-1]}}, b_r};
      invalid    = ((red_a_r | red_b_r) & (op_r[1] | op_r[2])) | (op_r[1] & op_r[2]);
      // When both flags are set the configured priority operand wins.
      pick_a_red = red_a_r & (~red_b_r | PRI_A);
      pick_a_byp = byp_a_r & (~byp_b_r | PRI_A);
      nxt_out    = '0;
      if (invalid) begin
         nxt_out = '0;
      end else if (byp_a_r | byp_b_r) begin
         nxt_out = pick_a_byp ? a_ext : b_ext;
      end else begin
         case (op_r)
            3'd0: begin
               if (red_a_r | red_b_r)
                  nxt_out = {{(OW-1){1'b0}}, pick_a_red ? |a_r : |b_r};
               else
                  nxt_out = a_ext | b_ext;
            end
            3'd1: begin
               if (red_a_r | red_b_r)
                  nxt_out = {{(OW-1){1'b0}}, pick_a_red ? ^a_r : ^b_r};
               else
                  nxt_out = a_ext ^ b_ext;
            end
            3'd2:    nxt_out = a_ext + b_ext + {{(OW-1){1'b0}}, cin_r & USE_CIN};
            3'd3:    nxt_out = a_ext * b_ext;
            3'd4:    nxt_out = dir_r ? {out[OW-2:0], ser_r} : {ser_r, out[OW-1:1]};
            3'd5:    nxt_out = dir_r ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
            default: nxt_out = '0;
         endcase
      end
   end

   // Stage 2: commit results only for valid ops; bubbles hold everything but out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         leds      <= '0;
         err_cnt   <= '0;
      end else begin
         out_valid <= vld_r;
         if (vld_r) begin
            out <= nxt_out;
            if (invalid) begin
               leds <= ~leds;
               if (err_cnt != {ERR_W{1'b1}})
                  err_cnt <= err_cnt + 1'b1;
            end else begin
               leds <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alsu_wide.sv
// Directed bench for alsu_wide (WIDTH=4, ERR_W=2) with an expectation queue.
// Each step drives one input set and queues the result expected two negedges later.
// Reset and bubble scenarios are checked inline where the queue cannot express them.
module tb_alsu_wide;

   typedef struct {
      logic       v;
      logic [2:0] op;
      logic [3:0] a, b;
      logic       cin, si, dir, ra, rb, ba, bb;
   } stim_t;

   typedef struct {
      logic [7:0]  out;
      logic        vld;
      logic [15:0] leds;
      logic [1:0]  err;
   } exp_t;

   logic              clk, rst, in_valid;
   logic signed [3:0] A, B;
   logic              cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
   logic [2:0]        opcode;
   logic signed [7:0] out;
   logic              out_valid;
   logic [15:0]       leds;
   logic [1:0]        err_cnt;

   int   checks = 0;
   int   errors = 0;
   int   idx    = 0;
   exp_t sb[$];

   alsu_wide #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_WIDTH(16), .ERR_W(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
      .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
      .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
      .opcode(opcode), .out(out), .out_valid(out_valid), .leds(leds), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t s(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      stim_t r;
      r.v = v; r.op = op; r.a = a; r.b = b;
      r.cin = 0; r.si = 0; r.dir = 0; r.ra = 0; r.rb = 0; r.ba = 0; r.bb = 0;
      return r;
   endfunction

   function automatic exp_t e(input logic [7:0] o, input logic v, input logic [15:0] l, input logic [1:0] c);
      exp_t r;
      r.out = o; r.vld = v; r.leds = l; r.err = c;
      return r;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s #%0d: observed %h expected %h", tag, idx, got, want);
      end
   endtask

   task automatic check_exp(input exp_t x);
      cmp("out",       {8'h00, out},       {8'h00, x.out});
      cmp("out_valid", {15'h0, out_valid}, {15'h0, x.vld});
      cmp("leds",      leds,               x.leds);
      cmp("err_cnt",   {14'h0, err_cnt},   {14'h0, x.err});
      idx++;
   endtask

   task automatic step(input stim_t st, input exp_t x);
      @(negedge clk);
      if (sb.size() >= 2) check_exp(sb.pop_front());
      in_valid = st.v; opcode = st.op; A = st.a; B = st.b;
      cin = st.cin; serial_in = st.si; direction = st.dir;
      red_op_A = st.ra; red_op_B = st.rb; bypass_A = st.ba; bypass_B = st.bb;
      sb.push_back(x);
   endtask

   stim_t st;
   exp_t  inv_exp[5];

   initial begin
      rst = 1'b1; in_valid = 0; A = 0; B = 0; cin = 0; serial_in = 0;
      red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0; direction = 0; opcode = 0;
      #3;
      check_exp(e(8'h00, 0, 16'h0000, 2'd0));
      @(negedge clk);
      rst = 1'b0;

      // ADD with carry: -3 + 5 + 1 = 3, then a bubble drops out_valid
      st = s(1, 3'd2, 4'hD, 4'h5); st.cin = 1;
      step(st, e(8'h03, 1, 16'h0000, 2'd0));
      step(s(0, 3'd0, 4'h0, 4'h0), e(8'h03, 0, 16'h0000, 2'd0));
      // MULT -8 * -8 = 64, then shift left with serial 1, then rotate right
      step(s(1, 3'd3, 4'h8, 4'h8), e(8'h40, 1, 16'h0000, 2'd0));
      st = s(1, 3'd4, 4'h0, 4'h0); st.dir = 1; st.si = 1;
      step(st, e(8'h81, 1, 16'h0000, 2'd0));
      st = s(1, 3'd5, 4'h0, 4'h0); st.dir = 0;
      step(st, e(8'hC0, 1, 16'h0000, 2'd0));
      // three bubbles hold out, then a right shift works on the held value
      repeat (3) step(s(0, 3'd4, 4'h0, 4'h0), e(8'hC0, 0, 16'h0000, 2'd0));
      step(s(1, 3'd4, 4'h0, 4'h0), e(8'h60, 1, 16'h0000, 2'd0));

      // five invalid ops: leds toggle, err_cnt saturates at 3 while leds keep toggling
      inv_exp[0] = e(8'h00, 1, 16'hFFFF, 2'd1);
      inv_exp[1] = e(8'h00, 1, 16'h0000, 2'd2);
      inv_exp[2] = e(8'h00, 1, 16'hFFFF, 2'd3);
      inv_exp[3] = e(8'h00, 1, 16'h0000, 2'd3);
      inv_exp[4] = e(8'h00, 1, 16'hFFFF, 2'd3);
      for (int i = 0; i < 5; i++) begin
         st = s(1, 3'd2, 4'h1, 4'h1); st.ra = 1;
         step(st, inv_exp[i]);
      end

      // next valid op clears leds: OR 0101|1010 = 1111, sign-extended
      step(s(1, 3'd0, 4'h5, 4'hA), e(8'hFF, 1, 16'h0000, 2'd3));
      // both bypass flags, priority A: 1101 sign-extended
      st = s(1, 3'd0, 4'hD, 4'h2); st.ba = 1; st.bb = 1;
      step(st, e(8'hFD, 1, 16'h0000, 2'd3));
      // reserved opcode beats bypass
      st = s(1, 3'd6, 4'hD, 4'h2); st.ba = 1; st.bb = 1;
      step(st, e(8'h00, 1, 16'hFFFF, 2'd3));
      // XOR reduction of B=0111 -> 1
      st = s(1, 3'd1, 4'h0, 4'h7); st.rb = 1;
      step(st, e(8'h01, 1, 16'h0000, 2'd3));
      // both reduction flags, OR, priority A: |0000 = 0 even though |B = 1
      st = s(1, 3'd0, 4'h0, 4'hF); st.ra = 1; st.rb = 1;
      step(st, e(8'h00, 1, 16'h0000, 2'd3));
      // plain XOR 0110^0011 = 0101
      step(s(1, 3'd1, 4'h6, 4'h3), e(8'h05, 1, 16'h0000, 2'd3));
      // most negative sum: -8 + -8 + 1 = -15
      st = s(1, 3'd2, 4'h8, 4'h8); st.cin = 1;
      step(st, e(8'hF1, 1, 16'h0000, 2'd3));
      repeat (2) step(s(0, 3'd0, 4'h0, 4'h0), e(8'hF1, 0, 16'h0000, 2'd3));

      // reset mid-operation: op captured, then rst pulsed before its result edge
      step(s(1, 3'd2, 4'h1, 4'h1), e(8'h02, 1, 16'h0000, 2'd3));
      @(posedge clk);
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check_exp(e(8'h00, 0, 16'h0000, 2'd0));
      #1 rst = 1'b0;
      sb.delete();
      step(s(0, 3'd0, 4'h0, 4'h0), e(8'h00, 0, 16'h0000, 2'd0));
      @(posedge clk);
      #1;
      check_exp(e(8'h00, 0, 16'h0000, 2'd0));
      step(s(0, 3'd0, 4'h0, 4'h0), e(8'h00, 0, 16'h0000, 2'd0));
      // first op after reset, without carry
      step(s(1, 3'd2, 4'h2, 4'h3), e(8'h05, 1, 16'h0000, 2'd0));
      repeat (4) step(s(0, 3'd0, 4'h0, 4'h0), e(8'h05, 0, 16'h0000, 2'd0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alsu_wide.md
# alsu_wide

Parametrised, pipelined successor to the 3-bit ALSU: operand width, LED width and error-counter width are generics. Adds a valid tag through the pipeline, hold-on-bubble behaviour and a saturating invalid-operation counter. Sits at the same place in the design as the fixed-width ALSU and feeds the same LED/status path. Fixed two-stage pipeline: input registers, then output registers.

## Interface
- WIDTH, 3: operand width of A/B (≥2); result width OW = 2*WIDTH
- INPUT_PRIORITY, "A": operand chosen when both bypass or both red_op flags are set ("A" or "B")
- FULL_ADDER, "ON": "ON" adds cin in ADD; "OFF" ignores cin
- LED_WIDTH, 16: width of leds
- ERR_W, 8: width of err_cnt
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  qualifies the input set this cycle
- A, B  in  WIDTH  signed operands
- cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction  in  1 each  control inputs
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 reserved
- out  out  OW  signed result register
- out_valid  out  1  out was updated by a valid operation this cycle
- leds  out  LED_WIDTH  error blink register
- err_cnt  out  ERR_W  saturating count of invalid operations

## Operation
- Stage 1: every rising edge registers all inputs including in_valid (no enable).
- Stage 2: acts on stage-1 registers. If stage-1 valid = 0: out, leds, err_cnt hold; out_valid = 0.
- invalid = ((red_op_A|red_op_B) & (opcode[1]|opcode[2])) | (opcode[1] & opcode[2]), on stage-1 values.
- Priority: invalid > bypass > opcode.
- Invalid op: out ← 0; leds ← ~leds; err_cnt ← err_cnt+1, saturating at all-ones; out_valid ← 1.
- Any valid (non-invalid) op: leds ← 0; out_valid ← 1.
- Bypass: bypass_A only → A; bypass_B only → B; both → per INPUT_PRIORITY. Sign-extended to OW.
- OR/XOR:
  - No red_op: A op B, bitwise, sign-extended.
  - red_op_A only → reduction of A; red_op_B only → reduction of B; both → per INPUT_PRIORITY.
  - Reduction result is zero-extended (0 or 1).
- ADD: sext(A)+sext(B)+cin (cin only when FULL_ADDER="ON"), OW bits; never overflows.
- MULT: signed A*B, OW bits exact.
- SHIFT, on current out:
  - direction=1 → {out[OW-2:0], serial_in}
  - direction=0 → {serial_in, out[OW-1:1]}
- ROTATE, on current out:
  - direction=1 → {out[OW-2:0], out[OW-1]}
  - direction=0 → {out[0], out[OW-1:1]}
- Back-to-back shift/rotate ops chain on the value just written.

## Timing
- Latency: inputs sampled at edge N appear on out/leds/err_cnt/out_valid after edge N+1.
- Throughput: 1 op/cycle; no backpressure.
- Reset, asynchronous and immediate: all stage-1 registers, out, leds, err_cnt and out_valid go to 0.
- First post-reset result: no earlier than the second rising edge after rst deasserts.
- Reset mid-operation: in-flight stage-1 data is discarded; no out_valid pulse for it.
- Bubble (in_valid=0) between ops: out keeps its last value; a following shift operates on that held value.
- err_cnt saturation and a leds toggle occur in the same cycle; leds keep toggling after err_cnt saturates.
- out_valid is high for exactly one cycle per accepted op.

## Test plan
- WIDTH=4, A=-3, B=5, cin=1, opcode=2, in_valid=1 at edge 0 → out=8'h03, out_valid=1 after edge 1; out_valid=0 the next cycle if in_valid dropped.
- WIDTH=4, A=-8, B=-8, opcode=3 → out=8'h40. Then opcode=4, dir=1, serial_in=1 → 8'h81. Then opcode=5, dir=0 → 8'hC0.
- WIDTH=3, red_op_A=1, opcode=2 (invalid), three consecutive cycles:
  - out=0 each cycle
  - leds 16'hFFFF, 16'h0000, 16'hFFFF
  - err_cnt 1, 2, 3
- Next valid op: leds=16'h0000.
- ERR_W=2: five invalid ops → err_cnt 1, 2, 3, 3, 3.
- WIDTH=3, bypass_A=bypass_B=1, A=3'b101, B=3'b010:
  - INPUT_PRIORITY="A" → out=6'b111101
  - with opcode=6 instead → out=0 (invalid wins over bypass)
- Reset and bubbles:
  - Valid op at edge N, rst pulsed between edges N and N+1 → all outputs 0 immediately, no out_valid at N+1.
  - in_valid=0 for 3 cycles → out holds its value, out_valid=0.
